df_wram_loader: RTL and testbench
=================================

Name: df_wram_loader

Overview:
Write-side counterpart of the neuron data-fetch path: loads the weight RAM that the fetch counter later reads.
- Accepts a stream of weight words over a valid/ready handshake.
- Writes them to consecutive WRAM word addresses and reports completion.
- Asserts a busy flag so the fetch path is held off while weights are being replaced.

Parameters:
N_WEIGHTS, 7, words per load session (one per neuron input, matching the 7-input fetch mux); range 1..2^ADDR_W.
DATA_W, 32, weight word width; equals `WordDataBus width.
ADDR_W, 30, WRAM address width; equals `WordAddrBus width.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
wl_start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
wl_base  input  ADDR_W  first WRAM address; sampled when wl_start is honoured.
wt_valid  input  1  weight word present on wt_data.
wt_data  input  DATA_W  weight word.
wt_ready  output  1  loader accepts wt_data this cycle.
wram_we  output  1  WRAM write strobe.
wram_addr  output  ADDR_W  WRAM write address.
wram_wdata  output  DATA_W  WRAM write data.
wl_busy  output  1  load in progress; fetch path must not start.
wl_done  output  1  last session completed; level signal.
wl_sum  output  DATA_W  running sum (mod 2^DATA_W) of the words written in the current or last session.

Behaviour:
- Reset (asynchronous, held high) forces:
  - state = IDLE;
  - wt_ready, wram_we, wl_busy and wl_done = 0;
  - wram_addr, wram_wdata, wl_sum and the internal count = 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on wl_start.
  - LOAD -> DONE on the clock edge that accepts word N_WEIGHTS.
  - DONE -> LOAD on wl_start.
  - No other transitions.
- Entering LOAD:
  - base latched from wl_base; count cleared to 0; wl_sum cleared to 0;
  - wl_done cleared; wl_busy set, all on the same edge.
- wt_ready = 1 only in LOAD. It is combinational from state; it does not depend on wt_valid.
- Transfer occurs on a rising edge where wt_valid && wt_ready. At that edge:
  - wram_we <= 1;
  - wram_addr <= base + count (mod 2^ADDR_W; wraps silently);
  - wram_wdata <= wt_data;
  - wl_sum <= wl_sum + wt_data (carry dropped);
  - count <= count + 1.
- Write latency: exactly 1 cycle from accept edge to wram_we high. wram_we is high for one cycle per accepted word. Back-to-back accepts give back-to-back writes.
- With no transfer in a cycle: wram_we <= 0. wram_addr and wram_wdata hold their last values.
- On the accept of word N_WEIGHTS:
  - state -> DONE;
  - wt_ready falls in the next cycle, so no extra word is accepted.
  - wl_busy stays 1 for one more cycle, covering the final write, then drops.
  - wl_done rises in the same cycle that wl_busy falls.
- wl_done stays high until the next honoured wl_start.
- wl_start while in LOAD is ignored: no restart, base and count are unchanged.
- wt_valid while in IDLE or DONE: no accept, no write, wl_sum unchanged.
- wl_start and wt_valid in the same cycle from IDLE/DONE: only the start is honoured. That word is not accepted because wt_ready is 0 that cycle.
- Reset asserted mid-LOAD: all outputs return to reset values immediately. A partial load leaves WRAM contents undefined; software must reload.
- Writes land on WRAM at the rising edge; the fetch side reads on the inverted clock. The loader guarantees no write activity once wl_busy = 0.

Decomposition:
- Shared package (stddef.h): `WordDataBus and `WordAddrBus widths; state encodings `WL_IDLE = 2'd0, `WL_LOAD = 2'd1, `WL_DONE = 2'd2; `ENABLE / `DISABLE levels.
- One natural sub-module, df_wram_loader_ctl: FSM plus count. The datapath registers (addr, wdata, sum) stay in the top module.

Test Plan:
1. Reset held then released, no stimulus -> all outputs 0, wt_ready = 0, for 10 cycles.
2. wl_start with wl_base = 0x10, then 7 back-to-back words 1..7 with wt_valid held high:
   - writes to 0x10..0x16 with data 1..7, each 1 cycle after its accept;
   - wl_sum = 28; wl_busy low one cycle after the last accept, with wl_done high in the same cycle.
3. Same session with wt_valid toggling 1,0,1,0…:
   - exactly 7 write pulses at addresses 0x10..0x16;
   - wram_we low in idle gaps, addr/wdata held.
4. wl_base = 2^30-3, words 0xFFFFFFFF x7:
   - addresses wrap to 2^30-3, 2^30-2, 2^30-1, 0, 1, 2, 3;
   - wl_sum = 0xFFFFFFF9.
5. wl_start pulsed again after word 3 during LOAD -> ignored; the session completes with 7 writes to the original base. Then a wl_start in DONE -> wl_done clears and a new session begins with wl_sum = 0.
6. reset asserted asynchronously, mid-cycle, after word 4 -> outputs go to 0 before the next edge. After release, wt_valid high with no wl_start -> no writes and wt_ready = 0.

Source files
------------

// File: rtl/df_wram_loader_pkg.sv
// Shared widths, levels and FSM encoding for the weight RAM loader.
package df_wram_loader_pkg;

  localparam int WORD_DATA_W = 32;  // weight word width
  localparam int WORD_ADDR_W = 30;  // WRAM word address width

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_LOAD = 2'd1,
    WL_DONE = 2'd2
  } wl_state_e;

endpackage

// File: rtl/df_wram_loader_ctl.sv
// Loader control: session FSM, word counter, busy/done flags.
module df_wram_loader_ctl
  import df_wram_loader_pkg::*;
#(
  parameter int N_WEIGHTS = 7,
  parameter int ADDR_W    = WORD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wl_start,
  input  logic              wt_valid,
  output logic              wt_ready,
  output logic              load_start,  // start honoured this cycle
  output logic              accept,      // word transfer this cycle
  output logic [ADDR_W-1:0] count,
  output logic              wl_busy,
  output logic              wl_done
);

  // Index of the final word; the counter wraps harmlessly when N_WEIGHTS
  // equals 2^ADDR_W because a new session always clears it first.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WEIGHTS - 1);

  wl_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WL_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake decode; ready depends on state only.
  always_comb begin
    state_d    = state_q;
    wt_ready   = DISABLE;
    load_start = DISABLE;
    accept     = DISABLE;
    case (state_q)
      WL_IDLE, WL_DONE: begin
        if (wl_start) begin
          load_start = ENABLE;
          state_d    = WL_LOAD;
        end
      end
      WL_LOAD: begin
        wt_ready = ENABLE;
        accept   = wt_valid;
        if (wt_valid && count == LAST) state_d = WL_DONE;
      end
      default: state_d = WL_IDLE;
    endcase
  end

  // Word counter: cleared on session start, bumped per accepted word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count <= '0;
    else if (load_start) count <= '0;
    else if (accept)     count <= count + 1'b1;
  end

  // Busy covers the session plus the cycle of the final write; done rises
  // exactly as busy falls and holds until the next honoured start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wl_busy <= DISABLE;
      wl_done <= DISABLE;
    end else if (load_start) begin
      wl_busy <= ENABLE;
      wl_done <= DISABLE;
    end else if (state_q == WL_DONE && wl_busy) begin
      wl_busy <= DISABLE;
      wl_done <= ENABLE;
    end
  end

endmodule

// File: rtl/df_wram_loader.sv
// Weight RAM loader: streams weight words into consecutive WRAM addresses.
module df_wram_loader
  import df_wram_loader_pkg::*;
#(
  parameter int N_WEIGHTS = 7,
  parameter int DATA_W    = WORD_DATA_W,
  parameter int ADDR_W    = WORD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wl_start,
  input  logic [ADDR_W-1:0] wl_base,
  input  logic              wt_valid,
  input  logic [DATA_W-1:0] wt_data,
  output logic              wt_ready,
  output logic              wram_we,
  output logic [ADDR_W-1:0] wram_addr,
  output logic [DATA_W-1:0] wram_wdata,
  output logic              wl_busy,
  output logic              wl_done,
  output logic [DATA_W-1:0] wl_sum
);

  logic              load_start;
  logic              accept;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] base_q;

  df_wram_loader_ctl #(
    .N_WEIGHTS (N_WEIGHTS),
    .ADDR_W    (ADDR_W)
  ) u_ctl (
    .clk        (clk),
    .reset      (reset),
    .wl_start   (wl_start),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .load_start (load_start),
    .accept     (accept),
    .count      (count),
    .wl_busy    (wl_busy),
    .wl_done    (wl_done)
  );

  // Session base: captured only when a start is honoured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           base_q <= '0;
    else if (load_start) base_q <= wl_base;
  end

  // Write port: one-cycle strobe per accepted word; addr/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wram_we    <= DISABLE;
      wram_addr  <= '0;
      wram_wdata <= '0;
    end else begin
      wram_we <= accept;
      if (accept) begin
        wram_addr  <= base_q + count;  // wraps modulo 2^ADDR_W
        wram_wdata <= wt_data;
      end
    end
  end

  // Running checksum of the session's words, carry dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           wl_sum <= '0;
    else if (load_start) wl_sum <= '0;
    else if (accept)     wl_sum <= wl_sum + wt_data;
  end

endmodule

// File: tb/tb_df_wram_loader.sv
// Self-checking bench for df_wram_loader against a transaction-level model.
module tb_df_wram_loader;

  localparam int N  = 7;
  localparam int DW = 32;
  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          wl_start;
  logic [AW-1:0] wl_base;
  logic          wt_valid;
  logic [DW-1:0] wt_data;
  logic          wt_ready;
  logic          wram_we;
  logic [AW-1:0] wram_addr;
  logic [DW-1:0] wram_wdata;
  logic          wl_busy;
  logic          wl_done;
  logic [DW-1:0] wl_sum;

  df_wram_loader #(.N_WEIGHTS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wl_start   (wl_start),
    .wl_base    (wl_base),
    .wt_valid   (wt_valid),
    .wt_data    (wt_data),
    .wt_ready   (wt_ready),
    .wram_we    (wram_we),
    .wram_addr  (wram_addr),
    .wram_wdata (wram_wdata),
    .wl_busy    (wl_busy),
    .wl_done    (wl_done),
    .wl_sum     (wl_sum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes;

  // Reference model: a session accepting N words, then one trailing
  // write cycle before it is reported complete.
  bit            m_load, m_tail, m_we, m_busy, m_done;
  int unsigned   m_cnt;
  logic [AW-1:0] m_base, m_addr;
  logic [DW-1:0] m_sum, m_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_tail = 0; m_we = 0; m_busy = 0; m_done = 0;
    m_cnt = 0; m_base = '0; m_addr = '0; m_sum = '0; m_wdata = '0;
  endtask

  task automatic model_edge(input bit s, input logic [AW-1:0] b, input bit v,
                            input logic [DW-1:0] d);
    bit acc;
    acc = m_load && v;
    if (m_tail) begin m_busy = 0; m_done = 1; m_tail = 0; end
    if (!m_load && s) begin
      m_load = 1; m_base = b; m_cnt = 0; m_sum = '0; m_done = 0; m_busy = 1;
    end
    if (acc) begin
      m_we    = 1;
      m_addr  = m_base + AW'(m_cnt);
      m_wdata = d;
      m_sum   = m_sum + d;
      m_cnt++;
      if (m_cnt == N) begin m_load = 0; m_tail = 1; end
    end else begin
      m_we = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, wt_ready,   m_load);
    chk({tag, ".we"},    wram_we,    m_we);
    chk({tag, ".addr"},  wram_addr,  m_addr);
    chk({tag, ".wdata"}, wram_wdata, m_wdata);
    chk({tag, ".sum"},   wl_sum,     m_sum);
    chk({tag, ".busy"},  wl_busy,    m_busy);
    chk({tag, ".done"},  wl_done,    m_done);
  endtask

  // One clock: drive at negedge, model at posedge, check 1 time unit later.
  task automatic step(input string tag, input bit s, input logic [AW-1:0] b,
                      input bit v, input logic [DW-1:0] d);
    @(negedge clk);
    wl_start = s; wl_base = b; wt_valid = v; wt_data = d;
    @(posedge clk);
    model_edge(s, b, v, d);
    #1;
    if (wram_we) n_writes++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, '0, 0, '0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    int k;
    reset = 1; wl_start = 0; wl_base = '0; wt_valid = 0; wt_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("t1_rst");
    @(negedge clk) reset = 0;
    idle("t1_idle", 10);

    // Back-to-back session, words 1..7 at base 0x10.
    step("t2_start", 1, AW'(32'h10), 0, '0);
    for (int i = 1; i <= N; i++) step("t2_word", 0, '0, 1, DW'(i));
    idle("t2_tail", 3);
    chk("t2_sum28", wl_sum, 64'd28);
    chk("t2_done", wl_done, 64'd1);

    // Same session with wt_valid toggling; exactly N writes expected.
    n_writes = 0;
    step("t3_start", 1, AW'(32'h10), 0, '0);
    k = 0;
    for (int i = 0; i < 40 && (m_load || i == 0); i++) begin
      if (i % 2 == 0) begin k++; step("t3_word", 0, '0, 1, DW'(k)); end
      else step("t3_gap", 0, '0, 0, DW'(32'hDEAD));
    end
    idle("t3_tail", 3);
    chk("t3_pulses", n_writes, N);

    // Address wrap near the top of WRAM, all-ones data.
    rb = '1; rb = rb - AW'(2);
    step("t4_start", 1, rb, 0, '0);
    for (int i = 0; i < N; i++) step("t4_word", 0, '0, 1, 32'hFFFF_FFFF);
    idle("t4_tail", 2);
    chk("t4_sum", wl_sum, 64'hFFFF_FFF9);

    // Start during LOAD ignored; start in DONE begins a fresh session.
    step("t5_start", 1, AW'(32'h40), 0, '0);
    for (int i = 1; i <= 3; i++) step("t5_word", 0, '0, 1, DW'(i));
    step("t5_restart", 1, AW'(32'h99), 1, DW'(4));
    for (int i = 5; i <= N; i++) step("t5_word", 0, '0, 1, DW'(i));
    idle("t5_tail", 2);
    chk("t5_lastaddr", wram_addr, 64'h46);
    step("t5_start2", 1, AW'(32'h200), 0, '0);
    chk("t5_done_clr", wl_done, 64'd0);
    chk("t5_sum_clr", wl_sum, 64'd0);

    // Asynchronous reset mid-session after word 4.
    for (int i = 1; i <= 4; i++) step("t6_word", 0, '0, 1, DW'(i * 3));
    #2 reset = 1;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    #1 check_all("t6_hold");
    @(negedge clk) reset = 0;
    n_writes = 0;
    for (int i = 0; i < 5; i++) step("t6_novld", 0, '0, 1, DW'(32'h55));
    chk("t6_nowrites", n_writes, 0);

    // Randomized sessions, including starts during LOAD and wrap bases.
    for (int i = 0; i < 600; i++) begin
      rb = AW'($urandom);
      if ($urandom_range(0, 3) == 0) begin rb = '1; rb = rb - AW'($urandom_range(0, 7)); end
      step("rnd", ($urandom_range(0, 11) == 0), rb, ($urandom_range(0, 9) < 6), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
